vga_timing_driver: RTL and testbench



---
 rtl/vga_timing_driver.sv | 111 +++++++++++
 tb/tb_vga_timing_driver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_driver.sv
// 640x480@60 VGA timing generator and output stage: sync/enable decode, one-clock-ahead pixel request.
// Optional build macro VGA_TIMING_PATTERN_EN replaces pixel_data with an internal 8-bar colour pattern.
module vga_timing_driver #(
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_FRONT = 16,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FRONT = 10
) (
  input  logic        driver_clk,
  input  logic        sys_rst_n,
  input  logic [29:0] pixel_data,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        data_req,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [29:0] vga_rgb,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int unsigned HS      = H_SYNC + H_BACK;
  localparam int unsigned VS      = V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] DE_H_START  = 10'(HS);
  localparam logic [9:0] DE_H_END    = 10'(HS + H_DISP);
  localparam logic [9:0] REQ_H_START = 10'(HS - 1);
  localparam logic [9:0] REQ_H_END   = 10'(HS + H_DISP - 1);
  localparam logic [9:0] V_START     = 10'(VS);
  localparam logic [9:0] V_END       = 10'(VS + V_DISP);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       v_active;

  always_ff @(posedge driver_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= (h_cnt == H_LAST) && (v_cnt == V_LAST);
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Decoded straight from the counters so an asynchronous reset clears them at once.
  always_comb begin
    vga_hs     = (h_cnt >= H_SYNC_END);
    vga_vs     = (v_cnt >= V_SYNC_END);
    v_active   = (v_cnt >= V_START) && (v_cnt < V_END);
    vga_de     = v_active && (h_cnt >= DE_H_START) && (h_cnt < DE_H_END);
    data_req   = v_active && (h_cnt >= REQ_H_START) && (h_cnt < REQ_H_END);
    pixel_xpos = data_req ? h_cnt - REQ_H_START : '0;
    pixel_ypos = data_req ? v_cnt - V_START : '0;
  end

`ifdef VGA_TIMING_PATTERN_EN
  logic [2:0]  bar_next;
  logic [2:0]  bar_idx;
  logic [29:0] bar_colour;
  logic        unused_data;

  assign unused_data = ^pixel_data;

  // Bars are 80 px wide, so the index comes from range compares rather than xpos bits.
  always_comb begin
    bar_next = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (pixel_xpos >= 10'(i * 80)) bar_next = 3'(i);
    end
  end

  always_ff @(posedge driver_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) bar_idx <= '0;
    else            bar_idx <= bar_next;
  end

  always_comb begin
    case (bar_idx)
      3'd0:    bar_colour = 30'h3FFFFFFF;
      3'd1:    bar_colour = 30'h3FFFFC00;
      3'd2:    bar_colour = 30'h000FFFFF;
      3'd3:    bar_colour = 30'h000FFC00;
      3'd4:    bar_colour = 30'h3FF003FF;
      3'd5:    bar_colour = 30'h3FF00000;
      3'd6:    bar_colour = 30'h000003FF;
      default: bar_colour = '0;
    endcase
    vga_rgb = vga_de ? bar_colour : '0;
  end
`else
  assign vga_rgb = vga_de ? pixel_data : '0;
`endif

endmodule

// File: tb/tb_vga_timing_driver.sv
// Bench for vga_timing_driver: a full-size instance checked through the first active line, and a
// shrunken instance checked over many frames plus an asynchronous mid-frame reset.
module tb_vga_timing_driver;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       req;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned na = 0;
  int unsigned nb = 0;
  logic seen_fs_b = 1'b0;
  logic [29:0] sb_a[$];
  logic [29:0] sb_b[$];

  logic [29:0] pd_a = '0, pd_b = '0, rgb_a, rgb_b;
  logic [9:0]  x_a, y_a, x_b, y_b;
  logic        req_a, hs_a, vs_a, de_a, fs_a;
  logic        req_b, hs_b, vs_b, de_b, fs_b;

  always #10 clk = ~clk;

  vga_timing_driver dut_a (
    .driver_clk(clk), .sys_rst_n(rst_a), .pixel_data(pd_a),
    .pixel_xpos(x_a), .pixel_ypos(y_a), .data_req(req_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .vga_de(de_a), .vga_rgb(rgb_a), .frame_start(fs_a)
  );

  vga_timing_driver #(
    .H_SYNC(4), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_DISP(4), .V_FRONT(1)
  ) dut_b (
    .driver_clk(clk), .sys_rst_n(rst_b), .pixel_data(pd_b),
    .pixel_xpos(x_b), .pixel_ypos(y_b), .data_req(req_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b), .vga_rgb(rgb_b), .frame_start(fs_b)
  );

  // Pixel stage: returns the requested coordinates one clock later.
  always @(posedge clk) begin
    pd_a <= {x_a, y_a, 10'h0};
    pd_b <= {x_b, y_b, 10'h0};
  end

  // Clocks elapsed since reset release.
  always @(posedge clk or negedge rst_a) if (!rst_a) na <= 0; else na <= na + 1;
  always @(posedge clk or negedge rst_b) if (!rst_b) nb <= 0; else nb <= nb + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned n,
                                 input int unsigned hsy, input int unsigned hbk,
                                 input int unsigned hd, input int unsigned hfr,
                                 input int unsigned vsy, input int unsigned vbk,
                                 input int unsigned vd, input int unsigned vfr);
    int unsigned ht, vt, h, v, hs0, vs0;
    logic vin;
    exp_t e;
    ht  = hsy + hbk + hd + hfr;
    vt  = vsy + vbk + vd + vfr;
    hs0 = hsy + hbk;
    vs0 = vsy + vbk;
    h   = n % ht;
    v   = (n / ht) % vt;
    vin   = (v >= vs0) && (v < vs0 + vd);
    e.hs  = (h >= hsy);
    e.vs  = (v >= vsy);
    e.de  = vin && (h >= hs0) && (h < hs0 + hd);
    e.req = vin && (h + 1 >= hs0) && (h + 1 < hs0 + hd);
    e.x   = e.req ? 10'(h + 1 - hs0) : 10'd0;
    e.y   = e.req ? 10'(v - vs0) : 10'd0;
    e.fs  = (n > 0) && (n % (ht * vt) == 0);
    return e;
  endfunction

  function automatic logic [29:0] exp_rgb(input logic [9:0] x, input logic [9:0] y);
`ifdef VGA_TIMING_PATTERN_EN
    logic [29:0] bars [8];
    bars = '{30'h3FFFFFFF, 30'h3FFFFC00, 30'h000FFFFF, 30'h000FFC00,
             30'h3FF003FF, 30'h3FF00000, 30'h000003FF, 30'h0};
    return (y === 10'h3FF) ? 30'h0 : bars[x / 80];
`else
    return {x, y, 10'h0};
`endif
  endfunction

  task automatic observe(input int idx, input int unsigned n, input exp_t e, input logic rst,
                         input logic hs, input logic vs, input logic de, input logic req,
                         input logic [9:0] x, input logic [9:0] y, input logic [29:0] rgb,
                         input logic fs);
    string p;
    logic [29:0] want;
    int unsigned depth;
    p = (idx == 0) ? "a_" : "b_";
    check({p, "hs"}, hs, e.hs);
    check({p, "vs"}, vs, e.vs);
    check({p, "de"}, de, e.de);
    check({p, "req"}, req, e.req);
    check({p, "xpos"}, x, e.x);
    check({p, "ypos"}, y, e.y);
    check({p, "frame_start"}, fs, e.fs);
    if (!rst) begin
      if (idx == 0) sb_a.delete(); else sb_b.delete();
    end
    depth = (idx == 0) ? sb_a.size() : sb_b.size();
    if (e.de) begin
      if (depth == 0) check({p, "sb_depth"}, depth, 1);
      else begin
        want = (idx == 0) ? sb_a.pop_front() : sb_b.pop_front();
        check({p, "rgb"}, rgb, want);
      end
    end else begin
      check({p, "rgb_blank"}, rgb, 0);
    end
    if (rst && e.req) begin
      if (idx == 0) sb_a.push_back(exp_rgb(e.x, e.y));
      else          sb_b.push_back(exp_rgb(e.x, e.y));
    end
  endtask

  always @(negedge clk) begin
    observe(0, na, model(na, 96, 48, 640, 16, 2, 33, 480, 10), rst_a,
            hs_a, vs_a, de_a, req_a, x_a, y_a, rgb_a, fs_a);
    observe(1, nb, model(nb, 4, 3, 8, 2, 2, 2, 4, 1), rst_b,
            hs_b, vs_b, de_b, req_b, x_b, y_b, rgb_b, fs_b);
    // Line-35 landmarks of the full-size timing.
    if (na == 35*800 + 142) check("line35_req_before", req_a, 0);
    if (na == 35*800 + 143) begin
      check("line35_req_rise", req_a, 1);
      check("line35_x0", x_a, 0);
      check("line35_y0", y_a, 0);
      check("line35_de_lag", de_a, 0);
    end
    if (na == 35*800 + 144) check("line35_de_rise", de_a, 1);
    if (na == 35*800 + 782) check("line35_x639", x_a, 639);
    if (na == 35*800 + 783) begin
      check("line35_req_fall", req_a, 0);
      check("line35_de_last", de_a, 1);
    end
    if (na == 35*800 + 784) check("line35_de_fall", de_a, 0);
    if (!rst_b) seen_fs_b = 1'b0;
    else if (fs_b && !seen_fs_b) begin
      seen_fs_b = 1'b1;
      check("b_first_frame_start", nb, 153);
    end
  end

  initial begin
    repeat (10) @(posedge clk);
    #5;
    check("rst_a_hs", hs_a, 0);
    check("rst_a_rgb", rgb_a, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    // Small instance: line 5, h 8 of its fourth frame, inside the active area.
    repeat (552) @(posedge clk);
    #5;
    check("b_pre_rst_de", de_b, 1);
    rst_b = 1'b0;
    #1;
    check("b_async_hs", hs_b, 0);
    check("b_async_vs", vs_b, 0);
    check("b_async_de", de_b, 0);
    check("b_async_req", req_b, 0);
    check("b_async_xpos", x_b, 0);
    check("b_async_rgb", rgb_b, 0);
    check("b_async_fs", fs_b, 0);
    repeat (3) @(posedge clk);
    #5;
    rst_b = 1'b1;
    repeat (36*800 + 10 - 555) @(posedge clk);
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
